mult_share_sched: RTL and testbench

//   Shares one combinational WxW array multiplier (generated tree, W=4) between NREQ requesters.

---
 rtl/mult_share_pkg.sv | 22 ++
 rtl/mult_share_sched_rr_arbiter.sv | 36 +++
 rtl/mult_share_sched.sv | 129 ++++++++++++
 tb/tb_mult_share_sched.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and constants for the shared-multiplier scheduler.
// Holds the FSM state encoding, default sizes and the round-robin pointer update.
package mult_share_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // The pointer moves past the winner so that it has the lowest priority next time.
    function automatic int unsigned rr_next(
        input int unsigned g,
        input int unsigned n
    );
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo NREQ.
// Ports: req (requests), ptr (start index), grant (one-hot), gidx (index), any (grant valid).
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gidx,
    output logic            any
);

    int idx;

    always_comb begin
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                gidx       = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/mult_share_sched.sv
// Shares one external combinational WxW multiplier between NREQ requesters, one op in flight.
// Ports: clk, rst_n, req_valid/ready/x/y (clients), rsp_valid/ready/id/prod (results),
// mul_x/mul_y/mul_o (multiplier), chk_err. Define MULT_SHARE_CHECK_EN for the product checker.
module mult_share_sched
    import mult_share_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int W    = W_DEF,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*W-1:0]    rsp_prod,
    output logic [W-1:0]      mul_x,
    output logic [W-1:0]      mul_y,
    input  logic [2*W-1:0]    mul_o,
    output logic              chk_err
);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [2*W-1:0] rsp_prod_q, rsp_prod_d;
    logic [W-1:0]   mul_x_q, mul_x_d;
    logic [W-1:0]   mul_y_q, mul_y_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            any;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .gidx  (gidx),
        .any   (any)
    );

    // rst_n gates ready so nothing looks accepted while reset is held.
    assign req_ready = (state_q == ST_IDLE && rst_n) ? grant : '0;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_prod  = rsp_prod_q;
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_prod_d = rsp_prod_q;
        mul_x_d    = mul_x_q;
        mul_y_d    = mul_y_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    mul_x_d  = req_x[int'(gidx)*W +: W];
                    mul_y_d  = req_y[int'(gidx)*W +: W];
                    rsp_id_d = gidx;
                    ptr_d    = IDW'(rr_next(32'(gidx), NREQ));
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                rsp_prod_d = mul_o;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            rsp_prod_q <= '0;
            mul_x_q    <= '0;
            mul_y_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_prod_q <= rsp_prod_d;
            mul_x_q    <= mul_x_d;
            mul_y_q    <= mul_y_d;
        end
    end

`ifdef MULT_SHARE_CHECK_EN
    logic           chk_err_q, chk_err_d;
    logic [2*W-1:0] ref_prod;

    always_comb begin
        ref_prod  = (2*W)'(mul_x_q) * (2*W)'(mul_y_q);
        chk_err_d = chk_err_q;
        if (state_q == ST_CALC && mul_o != ref_prod) begin
            chk_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_sched.sv
// Self-checking bench for mult_share_sched: vector table, directed corner sequences
// and a randomized run against a transaction-level reference model.
module tb_mult_share_sched;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic            clk;
    logic            rst_n;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [15:0]     req_x;
    logic [15:0]     req_y;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [7:0]      rsp_prod;
    logic [3:0]      mul_x;
    logic [3:0]      mul_y;
    logic [7:0]      mul_o;
    logic            chk_err;
    logic            bad_mul;

    int total = 0;
    int bad   = 0;

    // External multiplier stand-in; bad_mul forces a zero product.
    assign mul_o = bad_mul ? 8'h00 : 8'(mul_x) * 8'(mul_y);

    mult_share_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_o     (mul_o),
        .chk_err   (chk_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int       id;
        bit [3:0] x;
        bit [3:0] y;
        bit [7:0] prod;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Starts at negedge+1 in IDLE; one full single-requester transaction.
    task automatic do_op(input int id, input bit [3:0] x, input bit [3:0] y,
                         input bit [7:0] prod);
        req_valid          = 4'(1 << id);
        req_x[id*4 +: 4]   = x;
        req_y[id*4 +: 4]   = y;
        rsp_ready          = 1'b1;
        #1;
        chk("op_ready", req_ready, 32'(1 << id));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("op_calc_nv", rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("op_rsp_valid", rsp_valid, 1);
        chk("op_rsp_id", rsp_id, id);
        chk("op_rsp_prod", rsp_prod, prod);
        @(negedge clk);
        #1;
        chk("op_idle_nv", rsp_valid, 0);
    endtask

    // Reference model state: at most one transaction in flight.
    int       m_ptr;
    bit       m_busy;
    int       m_age;
    int       m_id;
    int       m_prod;

    task automatic run_random(input int ncyc);
        int       g;
        bit [3:0] exp_ready;
        bit       exp_valid;
        m_ptr  = 0;
        m_busy = 0;
        m_age  = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            req_valid = 4'($urandom_range(0, 15));
            req_x     = 16'($urandom);
            req_y     = 16'($urandom);
            rsp_ready = ($urandom % 4) != 0;
            #1;
            g = -1;
            if (!m_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) begin
                        g = (m_ptr + k) % NREQ;
                    end
                end
            end
            exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0;
            exp_valid = m_busy && m_age >= 2;
            chk("rnd_ready", req_ready, exp_ready);
            chk("rnd_valid", rsp_valid, exp_valid);
            if (exp_valid) begin
                chk("rnd_id", rsp_id, m_id);
                chk("rnd_prod", rsp_prod, m_prod);
            end
            if (m_busy) begin
                if (m_age >= 2) begin
                    if (rsp_ready) m_busy = 0;
                end else begin
                    m_age++;
                end
            end else if (g >= 0) begin
                m_busy = 1;
                m_age  = 1;
                m_id   = g;
                m_prod = int'(req_x[g*4 +: 4]) * int'(req_y[g*4 +: 4]);
                m_ptr  = (g + 1) % NREQ;
            end
        end
    endtask

    initial begin
        bit got;
        bit exp_chk;
        bad_mul   = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;

        vecs[0] = '{0, 4'h3, 4'h5, 8'h0F};
        vecs[1] = '{1, 4'hF, 4'hF, 8'hE1};
        vecs[2] = '{2, 4'h0, 4'hF, 8'h00};
        vecs[3] = '{3, 4'hF, 4'h0, 8'h00};
        vecs[4] = '{0, 4'h8, 4'h8, 8'h40};
        vecs[5] = '{1, 4'h7, 4'hB, 8'h4D};
        vecs[6] = '{2, 4'h1, 4'h1, 8'h01};
        vecs[7] = '{3, 4'hC, 4'hD, 8'h9C};
        vecs[8] = '{0, 4'hA, 4'h6, 8'h3C};
        vecs[9] = '{2, 4'h9, 4'hE, 8'h7E};

        // Reset values, with requests pending to show ready is held low.
        req_valid = 4'hF;
        @(negedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_prod", rsp_prod, 0);
        chk("rst_mulx", mul_x, 0);
        chk("rst_muly", mul_y, 0);
        chk("rst_chk", chk_err, 0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].prod);
        end

        // All four contending from ptr=0: strict 0,1,2,3 order.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_x[i*4 +: 4] = 4'(i + 1);
            req_y[i*4 +: 4] = 4'hF;
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", req_ready, 32'(1 << k));
            got = 0;
            for (int t = 0; t < 5 && !got; t++) begin
                @(negedge clk);
                #1;
                if (rsp_valid) got = 1;
            end
            chk("rr_got_rsp", got, 1);
            chk("rr_id", rsp_id, k);
            chk("rr_prod", rsp_prod, 32'((k + 1) * 15));
            @(negedge clk);
        end
        req_valid = 4'b1001;
        #1;
        chk("rr_wrap_ptr", req_ready, 4'b0001);
        req_valid = '0;

        // Grant on requester 3 wraps the pointer back to 0.
        do_op(3, 4'hF, 4'hF, 8'hE1);
        req_valid = 4'hF;
        #1;
        chk("wrap3_ready", req_ready, 4'b0001);
        req_valid = '0;

        // Consumer back-pressure for 5 cycles in RESP.
        req_valid       = 4'b0100;
        req_x[8 +: 4]   = 4'h7;
        req_y[8 +: 4]   = 4'h9;
        rsp_ready       = 1'b0;
        #1;
        chk("bp_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = 4'hF;
        @(negedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 2);
            chk("bp_prod", rsp_prod, 8'h3F);
            chk("bp_noready", req_ready, 0);
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_last_valid", rsp_valid, 1);
        @(negedge clk);
        #1;
        chk("bp_idle_nv", rsp_valid, 0);
        chk("bp_idle_ready", req_ready, 4'b1000);
        req_valid = '0;

        // Asynchronous reset while in CALC.
        do_reset();
        req_valid     = 4'b0001;
        req_x[0 +: 4] = 4'h5;
        req_y[0 +: 4] = 4'h5;
        rsp_ready     = 1'b1;
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("ar_in_calc_mulx", mul_x, 5);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", rsp_valid, 0);
        chk("ar_ready", req_ready, 0);
        chk("ar_id", rsp_id, 0);
        chk("ar_prod", rsp_prod, 0);
        chk("ar_mulx", mul_x, 0);
        chk("ar_muly", mul_y, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1001;
        #1;
        chk("ar_ptr0", req_ready, 4'b0001);
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("ar_no_stale", rsp_valid, 0);
        end

        // Faulty multiplier output.
`ifdef MULT_SHARE_CHECK_EN
        exp_chk = 1'b1;
`else
        exp_chk = 1'b0;
`endif
        bad_mul = 1'b1;
        do_op(1, 4'h2, 4'h3, 8'h00);
        chk("chk_set", chk_err, exp_chk);
        bad_mul = 1'b0;
        do_op(2, 4'h2, 4'h3, 8'h06);
        chk("chk_sticky", chk_err, exp_chk);
        do_reset();
        chk("chk_cleared", chk_err, 0);

        run_random(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
